// File: rtl/door_lock_sequencer_if.sv
// Button levels in, lock indications out, for the door lock sequencer.
// The master side drives the buttons; the sequencer is the slave.
interface door_lock_sequencer_if;
   logic       B0;
   logic       B1;
   logic       Correct;
   logic       Incorrect;
   logic       Lockout;
   logic [2:0] Fail_cnt;

   modport master (
      output B0,
      output B1,
      input  Correct,
      input  Incorrect,
      input  Lockout,
      input  Fail_cnt
   );

   modport slave (
      input  B0,
      input  B1,
      output Correct,
      output Incorrect,
      output Lockout,
      output Fail_cnt
   );
endinterface

// File: rtl/door_lock_sequencer.sv
// Two-button door lock sequencer: shifts presses into a code register, evaluates
// against CODE, and drives timed unlock / error / lockout indications.
//
// state    | meaning
// IDLE     | waiting for the first press of an entry
// ENTRY    | collecting presses, inactivity timer running
// EVAL     | one cycle comparing the collected code
// UNLOCKED | Correct held for UNLOCK_CYC cycles
// ERROR    | Incorrect held for ERR_CYC cycles
// LOCKOUT  | Lockout and Incorrect held for LOCKOUT_CYC cycles
module door_lock_sequencer #(
   parameter int                  CODE_LEN    = 4,
   parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
   parameter int                  MAX_FAIL    = 3,
   parameter int                  UNLOCK_CYC  = 8,
   parameter int                  ERR_CYC     = 4,
   parameter int                  LOCKOUT_CYC = 16,
   parameter int                  IDLE_CYC    = 32
) (
   input  logic                 mClk,
   input  logic                 Rst,
   door_lock_sequencer_if.slave bus
);

   localparam int MAX_UE  = (UNLOCK_CYC > ERR_CYC) ? UNLOCK_CYC : ERR_CYC;
   localparam int MAX_LI  = (LOCKOUT_CYC > IDLE_CYC) ? LOCKOUT_CYC : IDLE_CYC;
   localparam int MAX_CYC = (MAX_UE > MAX_LI) ? MAX_UE : MAX_LI;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int BCNT_W  = $clog2(CODE_LEN + 1);

   localparam logic [TMR_W-1:0]  UNLOCK_TC  = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0]  ERR_TC     = TMR_W'(ERR_CYC - 1);
   localparam logic [TMR_W-1:0]  LOCKOUT_TC = TMR_W'(LOCKOUT_CYC - 1);
   localparam logic [TMR_W-1:0]  IDLE_TC    = TMR_W'(IDLE_CYC - 1);
   localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(CODE_LEN - 1);
   localparam logic [2:0]        MAX_F      = 3'(MAX_FAIL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_EVAL,
      ST_UNLOCKED,
      ST_ERROR,
      ST_LOCKOUT
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [TMR_W-1:0]    timer;
   logic [BCNT_W-1:0]   bit_cnt;
   logic [CODE_LEN-1:0] sr;
   logic [2:0]          fail_cnt;
   logic                b0_q;
   logic                b1_q;
   logic                press0;
   logic                press1;
   logic                valid;
   logic                timer_clr;
   logic                correct_d;
   logic                incorrect_d;
   logic                lockout_d;
   logic                correct_q;
   logic                incorrect_q;
   logic                lockout_q;

   // Edge detect against the previous level, so a held button never re-presses.
   assign press0 = bus.B0 & ~b0_q;
   assign press1 = bus.B1 & ~b1_q;
   assign valid  = press0 ^ press1;

   always_ff @(posedge mClk or negedge Rst) begin
      if (!Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (valid) next_state = ST_ENTRY;
         end
         ST_ENTRY: begin
            if (valid) begin
               if (bit_cnt == LAST_BIT) next_state = ST_EVAL;
            end else if (timer == IDLE_TC) begin
               next_state = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (sr == CODE)                   next_state = ST_UNLOCKED;
            else if (fail_cnt + 3'd1 == MAX_F) next_state = ST_LOCKOUT;
            else                              next_state = ST_ERROR;
         end
         ST_UNLOCKED: begin
            if (timer == UNLOCK_TC) next_state = ST_IDLE;
         end
         ST_ERROR: begin
            if (timer == ERR_TC) next_state = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (timer == LOCKOUT_TC) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      correct_d   = 1'b0;
      incorrect_d = 1'b0;
      lockout_d   = 1'b0;
      case (state)
         ST_UNLOCKED: correct_d = 1'b1;
         ST_ERROR:    incorrect_d = 1'b1;
         ST_LOCKOUT: begin
            incorrect_d = 1'b1;
            lockout_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // Timer restarts on every state entry and on each accepted press during entry.
   assign timer_clr = (state != next_state) || (state == ST_IDLE) || (state == ST_EVAL) ||
                      ((state == ST_ENTRY) && valid);

   always_ff @(posedge mClk or negedge Rst) begin
      if (!Rst) begin
         b0_q     <= 1'b0;
         b1_q     <= 1'b0;
         timer    <= '0;
         bit_cnt  <= '0;
         sr       <= '0;
         fail_cnt <= 3'd0;
      end else begin
         b0_q <= bus.B0;
         b1_q <= bus.B1;

         if (timer_clr) timer <= '0;
         else           timer <= timer + 1'b1;

         case (state)
            ST_IDLE: begin
               if (valid) begin
                  sr      <= {sr[CODE_LEN-2:0], press1};
                  bit_cnt <= BCNT_W'(1);
               end else begin
                  bit_cnt <= '0;
               end
            end
            ST_ENTRY: begin
               if (valid) begin
                  sr      <= {sr[CODE_LEN-2:0], press1};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: bit_cnt <= '0;
         endcase

         if (state == ST_EVAL) begin
            if (sr == CODE)           fail_cnt <= 3'd0;
            else if (fail_cnt != MAX_F) fail_cnt <= fail_cnt + 3'd1;
         end else if ((state == ST_LOCKOUT) && (next_state == ST_IDLE)) begin
            fail_cnt <= 3'd0;
         end
      end
   end

   always_ff @(posedge mClk or negedge Rst) begin
      if (!Rst) begin
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         correct_q   <= correct_d;
         incorrect_q <= incorrect_d;
         lockout_q   <= lockout_d;
      end
   end

   assign bus.Correct   = correct_q;
   assign bus.Incorrect = incorrect_q;
   assign bus.Lockout   = lockout_q;
   assign bus.Fail_cnt  = fail_cnt;

endmodule

// File: doc/door_lock_sequencer.md
Name: door_lock_sequencer

Overview:
- Sequencing controller for the two-button door lock, running on the debounced button levels in the mClk domain.
- Shifts B0/B1 presses into a code register and compares against a parameterised code.
- Drives timed Correct/Incorrect indications, counts consecutive failures, and enforces a timed lockout after MAX_FAIL failures.
- Discards partial entries after an inactivity timeout.

Parameters:
- CODE_LEN, 4: number of button presses per code entry (2..8).
- CODE, 4'b1011: secret code; the first press lands in the MSB. B1=1, B0=0.
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout (1..7).
- UNLOCK_CYC, 8: mClk cycles that Correct is held.
- ERR_CYC, 4: mClk cycles that Incorrect is held after a non-locking failure.
- LOCKOUT_CYC, 16: mClk cycles of lockout.
- IDLE_CYC, 32: mClk cycles without a press before a partial entry is discarded.

Ports:
- mClk  input  1  system clock; all state is updated on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- B0  input  1  debounced level of button 0, synchronous to mClk.
- B1  input  1  debounced level of button 1, synchronous to mClk.
- Correct  output  1  registered; high while unlocked.
- Incorrect  output  1  registered; high during error indication and during lockout.
- Lockout  output  1  registered; high during lockout.
- Fail_cnt  output  3  registered; consecutive failure count.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE. The following are all cleared to 0:
  - Correct, Incorrect, Lockout, Fail_cnt;
  - shift register, bit counter, timer;
  - button history registers.
  - Reset asserted mid-operation aborts the operation immediately; no partial state survives.
- Press detection:
  - B0_q and B1_q register the previous levels every cycle, in every state.
  - press0 = B0 & ~B0_q; press1 = B1 & ~B1_q.
  - A valid press is exactly one of press0 or press1. Both in the same cycle means the press is ignored; nothing is shifted and the idle timer is not reset.
  - A button held across a state change never generates a second press.
- IDLE: timer=0, bit_cnt=0.
  - Valid press: shift in the bit, bit_cnt=1, go to ENTRY.
  - If CODE_LEN=... entry always needs ≥2 presses, so no evaluation happens from IDLE.
- ENTRY:
  - Valid press: sr <= {sr[CODE_LEN-2:0], press1}, bit_cnt++, timer=0.
  - If that press makes bit_cnt==CODE_LEN, go to EVAL.
  - No press: timer++. When timer reaches IDLE_CYC-1, return to IDLE. The partial entry is discarded and Fail_cnt is unchanged.
- EVAL (exactly one cycle, presses ignored):
  - sr==CODE: Fail_cnt=0, Correct=1, go to UNLOCKED.
  - Mismatch with Fail_cnt+1==MAX_FAIL: Fail_cnt=MAX_FAIL, Lockout=1, Incorrect=1, go to LOCKOUT.
  - Mismatch otherwise: Fail_cnt++, Incorrect=1, go to ERROR.
  - Latency: Correct/Incorrect rise on the second rising edge after the edge that samples the final press.
- UNLOCKED:
  - Correct held for exactly UNLOCK_CYC cycles.
  - Then Correct=0 and go to IDLE.
  - Presses are ignored.
- ERROR:
  - Incorrect held for exactly ERR_CYC cycles.
  - Then go to IDLE; Fail_cnt is retained.
  - Presses are ignored.
- LOCKOUT:
  - Lockout and Incorrect held for exactly LOCKOUT_CYC cycles.
  - Then both deassert, Fail_cnt=0, go to IDLE.
  - All presses are ignored.
- Timers: a single counter, width clog2 of the maximum of the *_CYC parameters. It is cleared on every state entry and never wraps. Fail_cnt saturates at MAX_FAIL.
- Invariant: Correct and Incorrect are never high in the same cycle.

Test Plan:
- Test parameters for all scenarios: defaults, except IDLE_CYC=32.
- Correct code: release Rst, then press B1,B0,B1,B1, each a 3-cycle high pulse with 3-cycle gaps -> Correct high for exactly 8 cycles, starting 2 edges after the last press is sampled; Fail_cnt=0; Incorrect stays 0.
- Wrong code, then correct code: enter 0000 -> Incorrect high for 4 cycles, Fail_cnt=1; then enter 1011 -> Correct for 8 cycles, Fail_cnt=0.
- Lockout: enter 0000 three times -> after the third entry, Lockout=Incorrect=1 for 16 cycles and Fail_cnt=3; presses during lockout produce no response; afterwards Fail_cnt=0 and 1011 unlocks.
- Idle timeout: press B1,B0, then wait 40 cycles, then press B1,B0,B1,B1 -> timeout discards the partial entry with no Incorrect; the second entry gives Correct.
- Simultaneous press and held button: B0 and B1 rise in the same cycle mid-entry -> ignored, bit count unchanged, entry completes with 4 single presses. B1 held high through the end of UNLOCKED -> no new press registered in IDLE.
- Reset mid-operation: assert Rst low during UNLOCKED, and separately during LOCKOUT -> all outputs are 0 asynchronously, Fail_cnt=0, and the next correct entry unlocks normally.
